// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings and defaults for the HI/LO multiply controller
//
// Purpose: operation encodings, controller state enum and default
// parameter values shared by mul_hilo_ctrl, hilo_regs and their users.
// Ports: none (package).

package mul_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_MTHI  = 2'd2,
      OP_MTLO  = 2'd3
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam int DEFAULT_LATENCY = 2;
   localparam int DEFAULT_CNT_W   = 4;

   // MULT and MULTU occupy the multiplier; MTHI/MTLO complete in one edge.
   function automatic logic is_mul(input op_e op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

endpackage

// File: rtl/mul_hilo_ctrl_if.sv
// rtl/mul_hilo_ctrl_if.sv - execute-stage request handshake into the multiply controller
//
// Purpose: groups the valid/ready request bus from the execute stage.
// Signals:
//   req_valid  execute stage presents an operation
//   req_ready  controller can accept this cycle
//   req_op     0=MULT, 1=MULTU, 2=MTHI, 3=MTLO
//   req_a      rs operand (sole data for MTHI/MTLO)
//   req_b      rt operand
// Modports: master = execute stage, slave = mul_hilo_ctrl.

interface mul_hilo_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;

   modport master (
      output req_valid,
      output req_op,
      output req_a,
      output req_b,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_a,
      input  req_b,
      output req_ready
   );

endinterface

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - architectural HI/LO register pair
//
// Purpose: holds HI and LO with independent single-word writes (MTHI/MTLO)
// and a joint 64-bit write (multiply commit).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   hi_we, hi_d        write HI with hi_d
//   lo_we, lo_d        write LO with lo_d
//   joint_we, joint_d  write {HI,LO} with joint_d
//   hi, lo             register outputs

module hilo_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        hi_we,
   input  logic [31:0] hi_d,
   input  logic        lo_we,
   input  logic [31:0] lo_d,
   input  logic        joint_we,
   input  logic [63:0] joint_d,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // The controller never raises a joint write together with a single-word
   // write (commit happens in WAIT, MTHI/MTLO only in IDLE); the joint write
   // still wins so the pair can never be left half-updated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (joint_we) begin
         hi <= joint_d[63:32];
         lo <= joint_d[31:0];
      end else begin
         if (hi_we) hi <= hi_d;
         if (lo_we) lo <= lo_d;
      end
   end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - issue controller and HI/LO owner for the combinational multiplier
//
// Purpose: accepts MULT/MULTU/MTHI/MTLO from execute, holds multiplier
// operands stable for LATENCY cycles, then commits the 64-bit product to
// HI/LO. Supports flush and reports busy for MFHI/MFLO stalls.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req (slave)                 valid/ready request bus from execute
//   flush                       aborts an in-flight multiply, blocks accept
//   mul_a, mul_b, mul_sign      registered operands to the multiplier
//   mul_product                 64-bit multiplier result
//   hi, lo                      architectural HI/LO
//   busy                        multiply in flight
//   done                        one-cycle pulse when a multiply commits

module mul_hilo_ctrl
   import mul_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input  logic                clk,
   input  logic                reset,
   mul_hilo_ctrl_if.slave      req,
   input  logic                flush,
   output logic [31:0]         mul_a,
   output logic [31:0]         mul_b,
   output logic                mul_sign,
   input  logic [63:0]         mul_product,
   output logic [31:0]         hi,
   output logic [31:0]         lo,
   output logic                busy,
   output logic                done
);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   op_e              op;
   logic             accept;
   logic             commit;

   assign op            = op_e'(req.req_op);
   assign req.req_ready = (state == IDLE) && !flush;
   assign accept        = req.req_valid && req.req_ready;
   // Product is sampled on the edge after the counter reaches zero, which
   // lands exactly LATENCY edges after the accepting edge.
   assign commit        = (state == WAIT) && (cnt == '0) && !flush;
   assign busy          = (state == WAIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         mul_sign <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (req.req_valid && is_mul(op)) begin
                     mul_a    <= req.req_a;
                     mul_b    <= req.req_b;
                     mul_sign <= (op == OP_MULT);
                     cnt      <= CNT_W'(LATENCY - 1);
                     state    <= WAIT;
                  end
               end
               WAIT: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end else begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   hilo_regs u_hilo_regs (
      .clk      (clk),
      .reset    (reset),
      .hi_we    (accept && (op == OP_MTHI)),
      .hi_d     (req.req_a),
      .lo_we    (accept && (op == OP_MTLO)),
      .lo_d     (req.req_a),
      .joint_we (commit),
      .joint_d  (mul_product),
      .hi       (hi),
      .lo       (lo)
   );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - self-checking bench for mul_hilo_ctrl

module tb_mul_hilo_ctrl;

   localparam int LAT = 2;

   logic        clk;
   logic        reset;
   logic        flush;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_sign;
   logic [63:0] mul_product;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   mul_hilo_ctrl_if req_if ();

   mul_hilo_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req_if),
      .flush       (flush),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_sign    (mul_sign),
      .mul_product (mul_product),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in for the combinational multiplier beside the controller.
   function automatic logic [63:0] mult64(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   assign mul_product = mult64(mul_a, mul_b, mul_sign);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A multiply accepted at edge k commits at edge k+LAT; flush cancels it.
   logic [31:0] m_hi, m_lo, m_a, m_b;
   logic        m_sign, m_pending, m_done;
   int          edge_n, commit_edge;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sign = 0;
         m_pending = 0; m_done = 0; edge_n = 0; commit_edge = 0;
      end else begin
         m_done = 0;
         if (flush) begin
            m_pending = 0;
         end else if (m_pending) begin
            if (edge_n == commit_edge) begin
               {m_hi, m_lo} = mult64(m_a, m_b, m_sign);
               m_done    = 1;
               m_pending = 0;
            end
         end else if (req_if.req_valid) begin
            case (req_if.req_op)
               2'd0, 2'd1: begin
                  m_pending   = 1;
                  m_a         = req_if.req_a;
                  m_b         = req_if.req_b;
                  m_sign      = (req_if.req_op == 2'd0);
                  commit_edge = edge_n + LAT;
               end
               2'd2: m_hi = req_if.req_a;
               default: m_lo = req_if.req_a;
            endcase
         end
         edge_n++;
      end
   end

   always @(negedge clk) begin
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("busy", 64'(busy), 64'(m_pending));
      chk("done", 64'(done), 64'(m_done));
      chk("req_ready", 64'(req_if.req_ready), 64'(!m_pending && !flush));
      chk("mul_a", 64'(mul_a), 64'(m_a));
      chk("mul_b", 64'(mul_b), 64'(m_b));
      chk("mul_sign", 64'(mul_sign), 64'(m_sign));
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Present a request and hold it until accepted; returns 2 units after
   // the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic got;
      got = 1'b0;
      req_if.req_valid = 1'b1;
      req_if.req_op    = op;
      req_if.req_a     = a;
      req_if.req_b     = b;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         got = req_if.req_ready;
         @(posedge clk);
         #2;
      end
      chk("accept_timeout", 64'(got), 64'd1);
      req_if.req_valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   logic [31:0] save_hi, save_lo;

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      req_if.req_valid = 1'b0;
      req_if.req_op    = 2'd0;
      req_if.req_a     = 32'd0;
      req_if.req_b     = 32'd0;
      step(3);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_ready", 64'(req_if.req_ready), 64'd1);
      reset = 1'b0;
      step(1);

      // signed -3 * 5
      issue(2'd0, 32'hFFFF_FFFD, 32'd5);
      chk("mult_busy", 64'(busy), 64'd1);
      step(LAT);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
      chk("mult_done", 64'(done), 64'd1);
      step(1);
      chk("mult_done_low", 64'(done), 64'd0);

      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step(LAT);
      chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0001);

      issue(2'd0, 32'h8000_0000, 32'h8000_0000);
      step(LAT);
      chk("mult_min_hi", 64'(hi), 64'h4000_0000);
      chk("mult_min_lo", 64'(lo), 64'h0);

      // back-to-back moves
      issue(2'd2, 32'h1234_5678, 32'd0);
      issue(2'd3, 32'h9ABC_DEF0, 32'd0);
      chk("mthi_hi", 64'(hi), 64'h1234_5678);
      chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
      chk("mt_busy", 64'(busy), 64'd0);

      // flush in first WAIT cycle
      save_hi = hi;
      save_lo = lo;
      issue(2'd0, 32'd7, 32'd6);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      step(LAT + 1);
      chk("flush_hi", 64'(hi), 64'(save_hi));
      chk("flush_lo", 64'(lo), 64'(save_lo));
      issue(2'd0, 32'd2, 32'd3);
      step(LAT);
      chk("after_flush_lo", 64'(lo), 64'd6);

      // flush while idle drops a valid request
      req_if.req_valid = 1'b1;
      req_if.req_op    = 2'd2;
      req_if.req_a     = 32'hDEAD_BEEF;
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      req_if.req_valid = 1'b0;
      chk("idle_flush_hi", 64'(hi), 64'h0);

      // MTLO held while busy lands after the commit
      issue(2'd1, 32'h10, 32'h1000_0000);
      issue(2'd3, 32'hCAFE_F00D, 32'd0);
      chk("hold_hi", 64'(hi), 64'h1);
      chk("hold_lo", 64'(lo), 64'hCAFE_F00D);

      // reset mid-WAIT
      issue(2'd0, 32'd3, 32'd3);
      reset = 1'b1;
      #3;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      step(1);
      reset = 1'b0;
      step(4);
      chk("rst_no_done_lo", 64'(lo), 64'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         req_if.req_valid = ($urandom_range(0, 3) != 0);
         req_if.req_op    = 2'($urandom_range(0, 3));
         req_if.req_a     = rnd32();
         req_if.req_b     = rnd32();
         flush            = ($urandom_range(0, 9) == 0);
         step(1);
      end
      req_if.req_valid = 1'b0;
      flush = 1'b0;
      step(LAT + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
